selector_entry_loader: RTL and testbench

Sequential front end for the selector stage. It accepts K address values one per handshake, tags each with its arrival index, and packs the pairs into the concatenated `{addr, index}` entry bus that the selector consumes. Downstream may treat the bus as stable only while `entries_valid` is high. The block sits directly upstream of the selector, which receives `packed_out` as its `inputs` bus.

---
 rtl/selector_entry_loader.sv | 61 ++++++
 tb/tb_selector_entry_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/selector_entry_loader.sv
// selector_entry_loader: packs K handshaked addresses with their arrival index into the selector entry bus.
// Optional duplicate-address detection is built when SELECTOR_LOADER_DUP_CHECK_EN is defined.
module selector_entry_loader #(
  parameter int SIZE = 16,
  parameter int K = 8,
  localparam int AW = $clog2(SIZE),
  localparam int IW = $clog2(K),
  localparam int EW = AW + IW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_addr,
  output logic [EW*K-1:0] packed_out,
  output logic            entries_valid,
  output logic [IW:0]     count,
  output logic            dup_err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state_q, state_d;
  logic accept;
  logic last_slot;
  // start wins over a same-cycle in_valid so a restart never keeps a stray entry
  assign accept = in_valid & in_ready & ~start;
  assign last_slot = count == (IW+1)'(K-1);
  always_comb begin
    in_ready = state_q == LOAD;
    entries_valid = state_q == DONE;
    state_d = start ? LOAD : (accept && last_slot) ? DONE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst || start) begin
      packed_out <= '0;
      count <= '0;
    end else if (accept) begin
      for (int i = 0; i < K; i++)
        if (count == (IW+1)'(i)) packed_out[i*EW +: EW] <= {in_addr, count[IW-1:0]};
      count <= count + (IW+1)'(1);
    end
  end
`ifdef SELECTOR_LOADER_DUP_CHECK_EN
  logic [K-1:0] match;
  always_comb begin
    match = '0;
    for (int i = 0; i < K; i++)
      match[i] = ((IW+1)'(i) < count) && (packed_out[(i+1)*EW-1 -: AW] == in_addr);
  end
  always_ff @(posedge clk) begin
    if (rst || start) dup_err <= 1'b0;
    else if (accept && |match) dup_err <= 1'b1;
  end
`else
  assign dup_err = 1'b0;
`endif
endmodule

// File: tb/tb_selector_entry_loader.sv
// tb_selector_entry_loader: directed scenarios for selector_entry_loader with K=8, SIZE=16.
module tb_selector_entry_loader;
  localparam int K = 8;
  localparam int SIZE = 16;
  localparam int EW = 7;
`ifdef SELECTOR_LOADER_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_addr = 4'd0;
  logic [EW*K-1:0] packed_out;
  logic entries_valid;
  logic [3:0] count;
  logic dup_err;
  int checks = 0;
  int failures = 0;
  logic [3:0] full_a [8] = '{4'd7, 4'd3, 4'd0, 4'd15, 4'd9, 4'd1, 4'd12, 4'd4};
  logic [3:0] new_a [8] = '{4'd2, 4'd14, 4'd6, 4'd8, 4'd10, 4'd5, 4'd11, 4'd13};
  logic [3:0] dup_a [8] = '{4'd5, 4'd2, 4'd5, 4'd1, 4'd3, 4'd7, 4'd9, 4'd0};

  selector_entry_loader #(.SIZE(SIZE), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .packed_out(packed_out), .entries_valid(entries_valid),
    .count(count), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  function automatic logic [EW*K-1:0] pack_of(input logic [3:0] a [8]);
    logic [EW*K-1:0] p = '0;
    for (int i = 0; i < K; i++) p[i*EW +: EW] = {a[i], 3'(i)};
    return p;
  endfunction

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({packed_out, count, entries_valid, in_ready, dup_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got packed=%h count=%0d ev=%b rdy=%b dup=%b want all 0", packed_out, count, entries_valid, in_ready, dup_err);
    end
    pulse_start;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_start_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_full_load;
    pulse_start;
    for (int i = 0; i < K; i++) begin
      in_valid = 1'b1;
      in_addr = full_a[i];
      @(negedge clk);
      checks++;
      if (count !== 4'(i + 1) || entries_valid !== (i == K - 1)) begin
        failures++;
        $display("FAIL full_step%0d got count=%0d ev=%b want count=%0d ev=%b", i, count, entries_valid, i + 1, i == K - 1);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (packed_out !== pack_of(full_a) || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_packed got %h rdy=%b want %h rdy=0", packed_out, in_ready, pack_of(full_a));
    end
    checks++;
    if (packed_out[27:21] !== {4'd15, 3'd3} || packed_out[6:0] !== {4'd7, 3'd0}) begin
      failures++;
      $display("FAIL full_slots got s3=%h s0=%h want s3=7b s0=38", packed_out[27:21], packed_out[6:0]);
    end
  endtask

  task automatic test_bubbles;
    int cycles = 0;
    int n = 0;
    pulse_start;
    while (!entries_valid && cycles < 40) begin
      in_valid = (cycles % 2) == 0;
      in_addr = in_valid ? full_a[n] : 4'hA;
      if (in_valid) n++;
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    checks++;
    if (cycles != 15 || packed_out !== pack_of(full_a)) begin
      failures++;
      $display("FAIL bubble_load got cycles=%0d packed=%h want cycles=15 packed=%h", cycles, packed_out, pack_of(full_a));
    end
    in_valid = 1'b1;
    in_addr = 4'd5;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (packed_out !== pack_of(full_a) || count !== 4'd8 || entries_valid !== 1'b1) begin
      failures++;
      $display("FAIL done_hold got packed=%h count=%0d ev=%b want %h 8 1", packed_out, count, entries_valid, pack_of(full_a));
    end
  endtask

  task automatic test_restart;
    pulse_start;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_addr = full_a[i];
      @(negedge clk);
    end
    start = 1'b1;
    in_addr = 4'd11;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd0 || packed_out !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear got count=%0d packed=%h rdy=%b want 0 0 1", count, packed_out, in_ready);
    end
    for (int i = 0; i < K; i++) begin
      in_valid = 1'b1;
      in_addr = new_a[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (packed_out !== pack_of(new_a) || entries_valid !== 1'b1 || count !== 4'd8) begin
      failures++;
      $display("FAIL restart_load got packed=%h ev=%b count=%0d want %h 1 8", packed_out, entries_valid, count, pack_of(new_a));
    end
  endtask

  task automatic test_reset_mid;
    pulse_start;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_addr = full_a[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({packed_out, count, entries_valid, in_ready, dup_err} !== '0) begin
      failures++;
      $display("FAIL reset_mid got packed=%h count=%0d ev=%b rdy=%b want all 0", packed_out, count, entries_valid, in_ready);
    end
    in_valid = 1'b1;
    in_addr = 4'd9;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd0 || packed_out !== '0 || in_ready !== 1'b0 || entries_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore got count=%0d packed=%h rdy=%b want 0 0 0", count, packed_out, in_ready);
    end
  endtask

  task automatic test_dup;
    pulse_start;
    for (int i = 0; i < K; i++) begin
      in_valid = 1'b1;
      in_addr = dup_a[i];
      @(negedge clk);
      checks++;
      if (dup_err !== (DUP_EN && i >= 2)) begin
        failures++;
        $display("FAIL dup_step%0d got %b want %b", i, dup_err, DUP_EN && i >= 2);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dup_err !== DUP_EN || entries_valid !== 1'b1 || packed_out !== pack_of(dup_a)) begin
      failures++;
      $display("FAIL dup_done got dup=%b ev=%b packed=%h want %b 1 %h", dup_err, entries_valid, packed_out, DUP_EN, pack_of(dup_a));
    end
    pulse_start;
    checks++;
    if (dup_err !== 1'b0 || entries_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL dup_clear got dup=%b ev=%b rdy=%b want 0 0 1", dup_err, entries_valid, in_ready);
    end
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_bubbles;
    test_restart;
    test_reset_mid;
    test_dup;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
